// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : traffic_phase_sequencer
// Brief   : Tick-timed phase register and registered lamp decode for a
//           two-road junction; optional flashing-amber mode (TRAFFIC_FLASH_EN).
// Revision: 1.0 - initial release
// ============================================================================
module traffic_phase_sequencer #(
    parameter int TICK_DIV    = 50000000,
    parameter int GREEN_TICKS = 5,
    parameter int PHASE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef TRAFFIC_FLASH_EN
    input  logic       flash,
`endif
    input  logic [2:0] nxt_s,
    output logic [2:0] s,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic       phase_load
);

    localparam int c_PRESC_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_DWELL_MAX = (GREEN_TICKS > PHASE_TICKS) ? GREEN_TICKS : PHASE_TICKS;
    localparam int c_DWELL_W   = $clog2(c_DWELL_MAX + 1);

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST  = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_GREEN = c_DWELL_W'(GREEN_TICKS);
    localparam logic [c_DWELL_W-1:0] c_DWELL_PHASE = c_DWELL_W'(PHASE_TICKS);
    localparam logic [c_DWELL_W-1:0] c_DWELL_ONE   = c_DWELL_W'(1);

    localparam logic [2:0] c_OFF = 3'b000;
    localparam logic [2:0] c_GRN = 3'b001;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_RNY = 3'b110;

    logic [c_PRESC_W-1:0] r_presc;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [2:0]           r_s;
    logic [2:0]           r_lightA;
    logic [2:0]           r_lightB;
    logic                 r_phaseLoad;
    logic                 w_tick;
    logic                 w_expire;
`ifdef TRAFFIC_FLASH_EN
    logic                 r_flashPrev;
    logic                 r_flashOdd;
`endif

    assign w_tick   = (r_presc == c_PRESC_LAST);
    assign w_expire = w_tick && (r_dwell == c_DWELL_ONE);

    // Returns {road A, road B}; green never appears on both halves.
    function automatic logic [5:0] lampDecode(input logic [2:0] st);
        case (st)
            3'd0:    lampDecode = {c_GRN, c_RED};
            3'd1:    lampDecode = {c_YEL, c_RED};
            3'd2:    lampDecode = {c_RED, c_RED};
            3'd3:    lampDecode = {c_RED, c_RNY};
            3'd4:    lampDecode = {c_RED, c_GRN};
            3'd5:    lampDecode = {c_RED, c_YEL};
            3'd6:    lampDecode = {c_RED, c_RED};
            default: lampDecode = {c_RNY, c_RED};
        endcase
    endfunction

    function automatic logic [c_DWELL_W-1:0] dwellFor(input logic [2:0] st);
        dwellFor = (st == 3'd0 || st == 3'd4) ? c_DWELL_GREEN : c_DWELL_PHASE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_dwell     <= c_DWELL_GREEN;
            r_s         <= 3'd0;
            r_lightA    <= c_GRN;
            r_lightB    <= c_RED;
            r_phaseLoad <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
            r_flashPrev <= 1'b0;
            r_flashOdd  <= 1'b0;
`endif
        end else begin
            r_phaseLoad <= 1'b0;
            r_presc     <= w_tick ? '0 : r_presc + 1'b1;
`ifdef TRAFFIC_FLASH_EN
            r_flashPrev <= flash;
            if (flash) begin
                // Lamps follow the parity the tick counter will hold after this edge.
                r_flashOdd <= r_flashOdd ^ w_tick;
                if (r_flashOdd ^ w_tick) begin
                    r_lightA <= c_OFF;
                    r_lightB <= c_OFF;
                end else begin
                    r_lightA <= c_YEL;
                    r_lightB <= c_YEL;
                end
            end else if (r_flashPrev) begin
                r_flashOdd            <= 1'b0;
                r_s                   <= 3'd2;
                r_dwell               <= c_DWELL_PHASE;
                r_presc               <= '0;
                {r_lightA, r_lightB}  <= lampDecode(3'd2);
                r_phaseLoad           <= 1'b1;
            end else
`endif
            if (w_expire) begin
                r_s                  <= nxt_s;
                r_dwell              <= dwellFor(nxt_s);
                {r_lightA, r_lightB} <= lampDecode(nxt_s);
                r_phaseLoad          <= 1'b1;
            end else if (w_tick && r_dwell != '0) begin
                r_dwell <= r_dwell - 1'b1;
            end
        end
    end

    assign s          = r_s;
    assign light_a    = r_lightA;
    assign light_b    = r_lightB;
    assign phase_load = r_phaseLoad;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// Randomized bench for traffic_phase_sequencer against a cycle-count model.
module tb_traffic_phase_sequencer;

    localparam int TD = 4;
    localparam int GT = 2;
    localparam int PT = 1;

    localparam logic [2:0] EXP_A [0:7] = '{3'b001, 3'b010, 3'b100, 3'b100,
                                           3'b100, 3'b100, 3'b100, 3'b110};
    localparam logic [2:0] EXP_B [0:7] = '{3'b100, 3'b100, 3'b100, 3'b110,
                                           3'b001, 3'b010, 3'b100, 3'b100};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] nxt_s;
    logic [2:0] s;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic       phase_load;
    bit         fl = 1'b0;
`ifdef TRAFFIC_FLASH_EN
    logic       flash;
    assign flash = fl;
`endif

    traffic_phase_sequencer #(
        .TICK_DIV   (TD),
        .GREEN_TICKS(GT),
        .PHASE_TICKS(PT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef TRAFFIC_FLASH_EN
        .flash     (flash),
`endif
        .nxt_s     (nxt_s),
        .s         (s),
        .light_a   (light_a),
        .light_b   (light_b),
        .phase_load(phase_load)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycles left in the phase, edges since the last prescaler restart.
    int mS, mRem, sinceSync;
    bit mLoad, mFlashOdd, prevFlash;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mS = 0; mRem = GT * TD; mLoad = 0; sinceSync = 0; mFlashOdd = 0; prevFlash = 0;
    endtask

    task automatic modelEdge(input logic [2:0] ns, input bit f);
        sinceSync++;
        mLoad = 0;
        if (f) begin
            if (sinceSync % TD == 0) mFlashOdd = ~mFlashOdd;
        end else if (prevFlash) begin
            mS = 2; mRem = PT * TD; sinceSync = 0; mLoad = 1; mFlashOdd = 0;
        end else begin
            mRem--;
            if (mRem == 0) begin
                mS    = ns;
                mRem  = ((ns == 3'd0 || ns == 3'd4) ? GT : PT) * TD;
                mLoad = 1;
            end
        end
        prevFlash = f;
    endtask

    task automatic checkOutputs(input string tag);
        checkEq({tag, ".s"}, 32'(s), 32'(mS));
        checkEq({tag, ".load"}, 32'(phase_load), 32'(mLoad));
        if (fl) begin
            checkEq({tag, ".flashA"}, 32'(light_a), mFlashOdd ? 32'd0 : 32'd2);
            checkEq({tag, ".flashB"}, 32'(light_b), mFlashOdd ? 32'd0 : 32'd2);
        end else begin
            checkEq({tag, ".lightA"}, 32'(light_a), 32'(EXP_A[mS]));
            checkEq({tag, ".lightB"}, 32'(light_b), 32'(EXP_B[mS]));
        end
        checkEq({tag, ".dblGreen"}, 32'(light_a[0] & light_b[0]), 32'd0);
    endtask

    task automatic cycle(input logic [2:0] ns, input string tag);
        nxt_s = ns;
        @(posedge clk);
        modelEdge(ns, fl);
        #1;
        checkOutputs(tag);
    endtask

    initial begin
        int loads;
        int guard;
        rst_n = 1'b0;
        nxt_s = 3'd1;
        modelReset();
        #12;
        checkOutputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First expiry lands on the eighth edge after release.
        repeat (7) cycle(3'd1, "startup");
        cycle(3'd1, "firstLoad");
        checkEq("firstLoad.s1", 32'(s), 32'd1);

        // Free-running junction: next state is current+1.
        repeat (44) cycle(3'(mS + 1), "sequence");

        // Advance to a fresh load into state 0, then hold for three expiries.
        guard = 0;
        while (!(mS == 0 && mLoad) && guard < 100) begin
            cycle(3'(mS + 1), "toZero");
            guard++;
        end
        checkEq("reachZero", 32'(guard < 100), 32'd1);
        loads = 0;
        for (int i = 0; i < 3 * GT * TD; i++) begin
            cycle(3'd0, "hold");
            loads += int'(phase_load);
        end
        checkEq("holdLoads", 32'(loads), 32'd3);

        // nxt_s churns every cycle; only the expiry-edge value matters.
        repeat (200) cycle(3'($urandom_range(0, 7)), "random");

        // Reach state 5 partway through its dwell, then pulse reset.
        guard = 0;
        while (!(mS == 5 && mRem == 2) && guard < 200) begin
            cycle(3'(mS + 1), "toFive");
            guard++;
        end
        checkEq("reachFive", 32'(guard < 200), 32'd1);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutputs("asyncReset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (GT * TD) cycle(3'($urandom_range(0, 7)), "postReset");
        checkEq("postReset.load", 32'(phase_load), 32'd1);
        repeat (30) cycle(3'($urandom_range(0, 7)), "random2");

`ifdef TRAFFIC_FLASH_EN
        fl = 1'b1;
        repeat (12) cycle(3'($urandom_range(0, 7)), "flash");
        fl = 1'b0;
        cycle(3'($urandom_range(0, 7)), "flashExit");
        checkEq("flashExit.s2", 32'(s), 32'd2);
        repeat (20) cycle(3'(mS + 1), "afterFlash");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_sequencer.md
TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; parameters and ports are listed in REQ-002 to REQ-011.
REQ-002 The module SHALL have parameter TICK_DIV, default 50000000, giving the number of clk cycles per timing tick (minimum 2).
REQ-003 The module SHALL have parameter GREEN_TICKS, default 5, giving the dwell in ticks for states 0 and 4 (minimum 1).
REQ-004 The module SHALL have parameter PHASE_TICKS, default 3, giving the dwell in ticks for all other states (minimum 1).
REQ-005 Port clk, input, 1 bit: system clock, rising-edge active.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port nxt_s, input, 3 bits: next state from the combinational next-state logic.
REQ-008 Port s, output, 3 bits: registered current state, fed back to the next-state logic.
REQ-009 Port light_a, output, 3 bits: road A lamps, ordered {red, yellow, green}.
REQ-010 Port light_b, output, 3 bits: road B lamps, ordered {red, yellow, green}.
REQ-011 Port phase_load, output, 1 bit: one-cycle pulse on the clk cycle in which s is updated.

Function
REQ-012 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; the internal tick SHALL be high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-013 The dwell counter SHALL hold the number of ticks remaining in the current state and SHALL decrement by 1 on each tick while it is nonzero.
REQ-014 On a tick with dwell equal to 1, the block SHALL take these actions on that clock edge:
- s <= nxt_s;
- dwell <= GREEN_TICKS if nxt_s is 0 or 4, otherwise PHASE_TICKS;
- phase_load SHALL be high for the following cycle.
REQ-015 When nxt_s equals s at expiry (a hold request from the next-state logic), the block SHALL still reload the dwell and pulse phase_load; s SHALL be unchanged.
REQ-016 nxt_s SHALL be sampled only on the expiry edge; changes to nxt_s at any other time SHALL have no effect.
REQ-017 All eight values of nxt_s SHALL be accepted; there is no illegal-state trap.
REQ-018 Lamp decode SHALL be registered, so light_a and light_b change on the same edge as s:
- s=0: A green (001), B red (100)
- s=1: A yellow (010), B red (100)
- s=2: A red (100), B red (100)
- s=3: A red (100), B red+yellow (110)
- s=4: A red (100), B green (001)
- s=5: A red (100), B yellow (010)
- s=6: A red (100), B red (100)
- s=7: A red+yellow (110), B red (100)
REQ-019 No state SHALL ever produce green on both roads.
REQ-020 The latency from the expiry tick to a lamp change SHALL be one clk edge, the same edge on which s updates.
REQ-021 The minimum time between consecutive phase_load pulses SHALL be TICK_DIV clk cycles, which occurs when the dwell is 1.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously force the following values:
- s = 0, light_a = 001, light_b = 100;
- prescaler = 0, dwell = GREEN_TICKS;
- phase_load = 0.
REQ-023 The first tick after reset release SHALL occur TICK_DIV cycles after the first active edge.
REQ-024 Reset asserted mid-dwell or mid-prescale SHALL discard all progress; no partial phase SHALL complete after reset release.

Configuration
REQ-025 When TRAFFIC_FLASH_EN is defined, the block SHALL add an input port flash, 1 bit, synchronous to clk.
REQ-026 While flash=1, the block SHALL behave as follows:
- light_a and light_b SHALL both be 010 on even ticks and 000 on odd ticks, toggling on each tick;
- s SHALL be frozen and phase_load SHALL stay 0;
- nxt_s SHALL be ignored.
REQ-027 On the first clk edge with flash=0 after flash=1, the block SHALL force the following values:
- s = 2, dwell = PHASE_TICKS, prescaler = 0;
- lamps = all-red decode;
- phase_load SHALL pulse for one cycle.
REQ-028 When TRAFFIC_FLASH_EN is undefined, the flash port and its logic SHALL be absent and behaviour SHALL be exactly as in REQ-012 to REQ-024.

Verification (bench parameters: TICK_DIV=4, GREEN_TICKS=2, PHASE_TICKS=1)
REQ-029 Reset release with nxt_s=1: phase_load SHALL first pulse after 8 clk cycles, then s=1, light_a=010, light_b=100.
REQ-030 Bench emulates the next-state logic with no cars (s+1 mod 8): the bench SHALL observe the sequence 0,1,2,...,7,0 with dwells of 8,4,4,4,8,4,4,4 cycles, every lamp pair matching REQ-018, and never green on both roads.
REQ-031 In s=0, hold nxt_s=0 for three expiries: s SHALL stay 0 and phase_load SHALL pulse every 8 cycles.
REQ-032 Toggle nxt_s every cycle mid-dwell: s SHALL change only to the value present on the expiry edge.
REQ-033 Assert rst_n=0 for one cycle during s=5 with dwell partly elapsed: outputs SHALL immediately show s=0, light_a=001, light_b=100, and the next load SHALL follow 8 cycles after release.
REQ-034 With TRAFFIC_FLASH_EN defined, hold flash=1 for 12 cycles and then release: both lamps SHALL alternate 010/000 every 4 cycles while s is frozen; on release s=2, both lamps are 100, and phase_load pulses once.
